// File: rtl/arcade_input_mapper.sv
// Per-player control mapper: merges PS/2 key events with MiSTer joystick words,
// applies screen rotation, stretches coin pulses and provides fire-0 autofire.
// All outputs are registered and active-high.
module arcade_input_mapper #(
  parameter int unsigned PLAYERS        = 2,
  parameter int unsigned BUTTONS        = 3,
  parameter int unsigned COIN_TICKS     = 4,
  parameter int unsigned AUTOFIRE_TICKS = 3
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [10:0]                  ps2_key,
  input  logic [16*PLAYERS-1:0]        joy,
  input  logic [1:0]                   rotate,
  input  logic                         tick,
  input  logic [PLAYERS-1:0]           autofire_en,
  output logic [4*PLAYERS-1:0]         p_dir,
  output logic [BUTTONS*PLAYERS-1:0]   p_btn,
  output logic [PLAYERS-1:0]           p_start,
  output logic [PLAYERS-1:0]           p_coin,
  output logic                         test
);

  // Scancode tables; direction entries are ordered {right, left, down, up} by index.
  localparam logic [7:0] DirCode   [2][4] = '{'{8'h74, 8'h6B, 8'h72, 8'h75},
                                              '{8'h34, 8'h23, 8'h2B, 8'h2D}};
  localparam logic [7:0] FireCode  [2][3] = '{'{8'h29, 8'h11, 8'h12},
                                              '{8'h1C, 8'h1B, 8'h15}};
  // Alternate fire codes repeat the primary where no alternate key exists.
  localparam logic [7:0] FireAlt   [2][3] = '{'{8'h14, 8'h11, 8'h12},
                                              '{8'h1C, 8'h1B, 8'h15}};
  localparam logic [7:0] StartCode [4]    = '{8'h16, 8'h1E, 8'h26, 8'h25};
  localparam logic [7:0] StartAlt  [4]    = '{8'h05, 8'h06, 8'h26, 8'h25};
  localparam logic [7:0] CoinCode  [4]    = '{8'h2E, 8'h36, 8'h3D, 8'h3E};
  localparam logic [7:0] TestCode         = 8'h2C;
  localparam logic [7:0] CoinLoad         = 8'(COIN_TICKS);
  localparam logic [7:0] AfLoad           = 8'(AUTOFIRE_TICKS);

  logic       tog_q;
  logic       key_event, key_pressed, key_ext;
  logic [7:0] key_code;
  logic       ktest_q, ktest_d;
  logic       unused_joy;

  assign key_event   = ps2_key[10] ^ tog_q;
  assign key_pressed = ps2_key[9];
  assign key_ext     = ps2_key[8];
  assign key_code    = ps2_key[7:0];
  assign unused_joy  = ^joy;

  // Toggle tracker; also loaded during reset so releasing reset never sees a stale edge.
  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[10];
  end

  // Test/service key state.
  always_comb begin
    ktest_d = ktest_q;
    if (key_event && !key_ext && key_code == TestCode) ktest_d = key_pressed;
  end

  // Test key register doubles as the output.
  always_ff @(posedge clk_sys) begin
    if (reset) ktest_q <= 1'b0;
    else       ktest_q <= ktest_d;
  end

  assign test = ktest_q;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    localparam int unsigned JoyBase = 16 * p;

    logic [3:0] kdir_d, dir_in, dir_rot, dir_q;
    logic       kstart_q, kstart_d, kcoin_q, kcoin_d;
    logic       start_q, coin_q, coin_raw, coin_prev_q;
    logic [7:0] coin_cnt_q, coin_cnt_d;

    if (p < 2) begin : g_dir_keys
      logic [3:0] kdir_q;

      // Direction keys ignore the extended flag so arrows and keypad both map.
      always_comb begin
        kdir_d = kdir_q;
        if (key_event) begin
          if (key_code == DirCode[p][0]) kdir_d[0] = key_pressed;
          if (key_code == DirCode[p][1]) kdir_d[1] = key_pressed;
          if (key_code == DirCode[p][2]) kdir_d[2] = key_pressed;
          if (key_code == DirCode[p][3]) kdir_d[3] = key_pressed;
        end
      end

      // Direction key state.
      always_ff @(posedge clk_sys) begin
        if (reset) kdir_q <= '0;
        else       kdir_q <= kdir_d;
      end
    end else begin : g_no_dir_keys
      assign kdir_d = '0;
    end

    // Start and coin keys require the extended flag clear.
    always_comb begin
      kstart_d = kstart_q;
      kcoin_d  = kcoin_q;
      if (key_event && !key_ext) begin
        if (key_code == StartCode[p] || key_code == StartAlt[p]) kstart_d = key_pressed;
        if (key_code == CoinCode[p]) kcoin_d = key_pressed;
      end
    end

    assign dir_in   = kdir_d | joy[JoyBase +: 4];
    assign coin_raw = kcoin_d | joy[JoyBase + 5 + BUTTONS];

    // Rotation of merged directions, bit order {up, down, left, right}.
    always_comb begin
      dir_rot = dir_in;
      case (rotate)
        2'd1:    dir_rot = {dir_in[1], dir_in[0], dir_in[2], dir_in[3]};
        2'd2:    dir_rot = {dir_in[0], dir_in[1], dir_in[3], dir_in[2]};
        2'd3:    dir_rot = {dir_in[2], dir_in[3], dir_in[0], dir_in[1]};
        default: dir_rot = dir_in;
      endcase
    end

    // Coin stretcher: a rising edge loads, ticks count down; a coincident tick is ignored.
    always_comb begin
      coin_cnt_d = coin_cnt_q;
      if (coin_raw && !coin_prev_q)           coin_cnt_d = CoinLoad;
      else if (tick && coin_cnt_q != 8'd0)    coin_cnt_d = coin_cnt_q - 8'd1;
    end

    // Key state, coin counter and registered outputs.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        kstart_q    <= 1'b0;
        kcoin_q     <= 1'b0;
        coin_prev_q <= 1'b0;
        coin_cnt_q  <= 8'd0;
        dir_q       <= '0;
        start_q     <= 1'b0;
        coin_q      <= 1'b0;
      end else begin
        kstart_q    <= kstart_d;
        kcoin_q     <= kcoin_d;
        coin_prev_q <= coin_raw;
        coin_cnt_q  <= coin_cnt_d;
        dir_q       <= dir_rot;
        start_q     <= kstart_d | joy[JoyBase + 4 + BUTTONS];
        coin_q      <= coin_raw | (coin_cnt_d != 8'd0);
      end
    end

    assign p_dir[4*p +: 4] = dir_q;
    assign p_start[p]      = start_q;
    assign p_coin[p]       = coin_q;

    for (genvar b = 0; b < BUTTONS; b++) begin : g_btn
      logic kfire_d, fire_raw, btn_d, btn_q;

      if (p < 2 && b < 3) begin : g_fire_key
        logic kfire_q;

        // Fire key state.
        always_comb begin
          kfire_d = kfire_q;
          if (key_event && !key_ext &&
              (key_code == FireCode[p][b] || key_code == FireAlt[p][b])) begin
            kfire_d = key_pressed;
          end
        end

        // Fire key register.
        always_ff @(posedge clk_sys) begin
          if (reset) kfire_q <= 1'b0;
          else       kfire_q <= kfire_d;
        end
      end else begin : g_no_fire_key
        assign kfire_d = 1'b0;
      end

      assign fire_raw = kfire_d | joy[JoyBase + 4 + b];

      if (b == 0) begin : g_autofire
        logic [7:0] af_cnt_q, af_cnt_d;

        // Autofire: a zero counter marks the first held cycle, which fires immediately.
        always_comb begin
          btn_d    = btn_q;
          af_cnt_d = af_cnt_q;
          if (!autofire_en[p] || !fire_raw) begin
            btn_d    = fire_raw;
            af_cnt_d = 8'd0;
          end else if (af_cnt_q == 8'd0) begin
            btn_d    = 1'b1;
            af_cnt_d = AfLoad;
          end else if (tick) begin
            if (af_cnt_q == 8'd1) begin
              btn_d    = ~btn_q;
              af_cnt_d = AfLoad;
            end else begin
              af_cnt_d = af_cnt_q - 8'd1;
            end
          end
        end

        // Autofire half-period counter.
        always_ff @(posedge clk_sys) begin
          if (reset) af_cnt_q <= 8'd0;
          else       af_cnt_q <= af_cnt_d;
        end
      end else begin : g_plain
        assign btn_d = fire_raw;
      end

      // Registered button output.
      always_ff @(posedge clk_sys) begin
        if (reset) btn_q <= 1'b0;
        else       btn_q <= btn_d;
      end

      assign p_btn[p*BUTTONS + b] = btn_q;
    end
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Randomized bench for arcade_input_mapper with a behavioural reference model.
module tb_arcade_input_mapper;

  localparam int P  = 2;
  localparam int B  = 3;
  localparam int CT = 4;
  localparam int AT = 3;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [10:0]       ps2_key;
  logic [16*P-1:0]   joy;
  logic [1:0]        rotate;
  logic              tick;
  logic [P-1:0]      autofire_en;
  logic [4*P-1:0]    p_dir;
  logic [B*P-1:0]    p_btn;
  logic [P-1:0]      p_start, p_coin;
  logic              test;

  arcade_input_mapper #(
    .PLAYERS(P), .BUTTONS(B), .COIN_TICKS(CT), .AUTOFIRE_TICKS(AT)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy(joy), .rotate(rotate),
    .tick(tick), .autofire_en(autofire_en), .p_dir(p_dir), .p_btn(p_btn),
    .p_start(p_start), .p_coin(p_coin), .test(test)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: held keys per player plus timers in "ticks since" form.
  logic       m_tog;
  logic [3:0] m_kdir  [4];
  logic [3:0] m_kfire [4];
  logic       m_kstart[4];
  logic       m_kcoin [4];
  logic       m_ktest;
  bit         m_coin_prev[4];
  int         m_coin_t   [4];
  bit         m_af_act   [4];
  int         m_af_k     [4];

  logic [4*P-1:0] e_dir;
  logic [B*P-1:0] e_btn;
  logic [P-1:0]   e_start, e_coin;
  logic           e_test;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic apply_key();
    logic pr, ex;
    logic [7:0] c;
    pr = ps2_key[9];
    ex = ps2_key[8];
    c  = ps2_key[7:0];
    case (c)
      8'h75: m_kdir[0][3] = pr;
      8'h72: m_kdir[0][2] = pr;
      8'h6B: m_kdir[0][1] = pr;
      8'h74: m_kdir[0][0] = pr;
      8'h2D: m_kdir[1][3] = pr;
      8'h2B: m_kdir[1][2] = pr;
      8'h23: m_kdir[1][1] = pr;
      8'h34: m_kdir[1][0] = pr;
      default: ;
    endcase
    if (!ex) begin
      case (c)
        8'h29, 8'h14: m_kfire[0][0] = pr;
        8'h11:        m_kfire[0][1] = pr;
        8'h12:        m_kfire[0][2] = pr;
        8'h1C:        m_kfire[1][0] = pr;
        8'h1B:        m_kfire[1][1] = pr;
        8'h15:        m_kfire[1][2] = pr;
        8'h16, 8'h05: m_kstart[0] = pr;
        8'h1E, 8'h06: m_kstart[1] = pr;
        8'h26:        m_kstart[2] = pr;
        8'h25:        m_kstart[3] = pr;
        8'h2E:        m_kcoin[0] = pr;
        8'h36:        m_kcoin[1] = pr;
        8'h3D:        m_kcoin[2] = pr;
        8'h3E:        m_kcoin[3] = pr;
        8'h2C:        m_ktest = pr;
        default: ;
      endcase
    end
  endtask

  // Advance the model by one clock edge, yielding the outputs the DUT should now show.
  task automatic model_step();
    logic [15:0] jw;
    logic [3:0]  md;
    logic        up, dn, lf, rt, raw, rc;
    if (reset) begin
      for (int p = 0; p < 4; p++) begin
        m_kdir[p] = '0; m_kfire[p] = '0; m_kstart[p] = 1'b0; m_kcoin[p] = 1'b0;
        m_coin_prev[p] = 1'b0; m_coin_t[p] = CT; m_af_act[p] = 1'b0; m_af_k[p] = 0;
      end
      m_ktest = 1'b0;
      m_tog   = ps2_key[10];
      e_dir = '0; e_btn = '0; e_start = '0; e_coin = '0; e_test = 1'b0;
    end else begin
      if (ps2_key[10] != m_tog) apply_key();
      m_tog = ps2_key[10];
      for (int p = 0; p < P; p++) begin
        jw = joy[16*p +: 16];
        md = m_kdir[p] | jw[3:0];
        up = md[3]; dn = md[2]; lf = md[1]; rt = md[0];
        case (rotate)
          2'd0: e_dir[4*p +: 4] = {up, dn, lf, rt};
          2'd1: e_dir[4*p +: 4] = {lf, rt, dn, up};
          2'd2: e_dir[4*p +: 4] = {rt, lf, up, dn};
          default: e_dir[4*p +: 4] = {dn, up, rt, lf};
        endcase
        for (int b = 0; b < B; b++) begin
          raw = m_kfire[p][b] | jw[4+b];
          if (b == 0 && autofire_en[p] && raw) begin
            if (!m_af_act[p]) begin
              m_af_act[p] = 1'b1;
              m_af_k[p]   = 0;
            end else if (tick) begin
              m_af_k[p]++;
            end
            e_btn[p*B + b] = ((m_af_k[p] / AT) % 2) == 0;
          end else begin
            if (b == 0) m_af_act[p] = 1'b0;
            e_btn[p*B + b] = raw;
          end
        end
        e_start[p] = m_kstart[p] | jw[4+B];
        rc = m_kcoin[p] | jw[5+B];
        if (rc && !m_coin_prev[p])         m_coin_t[p] = 0;
        else if (tick && m_coin_t[p] < CT) m_coin_t[p]++;
        m_coin_prev[p] = rc;
        e_coin[p] = rc || (m_coin_t[p] < CT);
      end
      e_test = m_ktest;
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_step();
    #1;
    check_eq("p_dir",   32'(p_dir),   32'(e_dir));
    check_eq("p_btn",   32'(p_btn),   32'(e_btn));
    check_eq("p_start", 32'(p_start), 32'(e_start));
    check_eq("p_coin",  32'(p_coin),  32'(e_coin));
    check_eq("test",    32'(test),    32'(e_test));
  endtask

  task automatic send_key(input logic pr, input logic ex, input logic [7:0] c);
    ps2_key = {~ps2_key[10], pr, ex, c};
    step();
  endtask

  task automatic tick_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
  endtask

  logic [7:0] codes [28] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h11, 8'h12,
                             8'h16, 8'h05, 8'h2E, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C,
                             8'h1B, 8'h15, 8'h1E, 8'h06, 8'h36, 8'h26, 8'h25, 8'h3D,
                             8'h3E, 8'h2C, 8'h5A, 8'h00};

  initial begin
    reset = 1'b1; ps2_key = 11'h400; joy = '0; rotate = 2'd0; tick = 1'b0;
    autofire_en = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // Keyboard up for P1, then release.
    send_key(1'b1, 1'b0, 8'h75); step();
    send_key(1'b0, 1'b0, 8'h75); step();

    // Joystick up under every rotation.
    joy[3] = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rotate = 2'(r); step(); step();
    end
    joy = '0; rotate = 2'd0; step();

    // Coin pulse from a one-cycle key press, then a reload mid-pulse.
    send_key(1'b1, 1'b0, 8'h2E);
    send_key(1'b0, 1'b0, 8'h2E);
    tick_pulses(6);
    send_key(1'b1, 1'b0, 8'h2E);
    send_key(1'b0, 1'b0, 8'h2E);
    tick_pulses(2);
    send_key(1'b1, 1'b0, 8'h2E);
    send_key(1'b0, 1'b0, 8'h2E);
    tick_pulses(6);

    // Autofire on P1, plain follow on P2.
    autofire_en = 2'b01; joy[4] = 1'b1; joy[20] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick = (i % 3 == 0); step();
    end
    tick = 1'b0; joy[4] = 1'b0; step(); step();
    joy[4] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick = (i % 2 == 0); step();
    end
    tick = 1'b0; autofire_en = 2'b00; step(); step();
    joy = '0; step();

    // Absent player, extended-flag rejection, test key.
    send_key(1'b1, 1'b0, 8'h26); step();
    send_key(1'b1, 1'b1, 8'h1C); step();
    send_key(1'b1, 1'b0, 8'h2C); step();
    send_key(1'b0, 1'b0, 8'h2C); step();

    // Reset while keys are held and a coin pulse runs.
    send_key(1'b1, 1'b0, 8'h16);
    send_key(1'b1, 1'b0, 8'h2E);
    send_key(1'b1, 1'b0, 8'h75);
    step();
    reset = 1'b1; step();
    reset = 1'b0; repeat (4) step();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      int j;
      if ($urandom_range(0, 2) == 0) begin
        ps2_key[10]   = ~ps2_key[10];
        ps2_key[9]    = 1'($urandom_range(0, 1));
        ps2_key[8]    = ($urandom_range(0, 3) == 0);
        ps2_key[7:0]  = codes[$urandom_range(0, 27)];
      end
      if ($urandom_range(0, 3) == 0) begin
        j = int'($urandom_range(0, 16*P - 1));
        joy[j] = ~joy[j];
      end
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 31) == 0) rotate = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) autofire_en = P'($urandom_range(0, 3));
      reset = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
